credit_interconnect_pipe: RTL and testbench

- Parametrised successor to the single-stage credit interconnect register.
- Inserts NUM_STAGES of retiming registers on NUM_CHANNELS independent latency-insensitive links.
- Each link has a forward path (data + valid) and a reverse credit path (increment_count).
- Adds synchronous reset, a forward-path flush, optional data hold for power, and per-channel in-flight occupancy counters for shell-level credit sizing and debug.

---
 rtl/credit_interconnect_pkg.sv | 14 +
 rtl/credit_interconnect_stage.sv | 60 ++++++
 rtl/credit_interconnect_pipe.sv | 94 +++++++++
 tb/tb_credit_interconnect_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/credit_interconnect_pkg.sv
// Shared helpers for the credit interconnect pipe.
//   cnt_width(n)        : bits needed to hold a count of 0..n
//   slice_lsb(chan, w)  : LSB of channel 'chan' in a flat bus of w-bit slices
package credit_interconnect_pkg;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int slice_lsb(input int chan, input int width);
        return chan * width;
    endfunction

endpackage

// File: rtl/credit_interconnect_stage.sv
// One retiming stage across all channels of the credit interconnect.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   flush                 : forces every valid captured this edge to 0
//   up_valid/up_credit    : per-channel valid / credit from the previous stage
//   up_data               : flat payload bus, DATA_WIDTH bits per channel
//   dn_valid/dn_credit    : registered valid / credit toward the next stage
//   dn_data               : registered payload
module credit_interconnect_stage
    import credit_interconnect_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHANNELS = 1,
    parameter int HOLD_DATA    = 0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [NUM_CHANNELS-1:0]            up_valid,
    input  logic [NUM_CHANNELS-1:0]            up_credit,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] up_data,
    output logic [NUM_CHANNELS-1:0]            dn_valid,
    output logic [NUM_CHANNELS-1:0]            dn_credit,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] dn_data
);

    localparam bit LOAD_ALWAYS = (HOLD_DATA == 0);

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        logic                  valid_reg;
        logic                  credit_reg;
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  valid_next;

        // Flush kills the token being captured; credits are never dropped
        // because losing one would starve the sender permanently.
        assign valid_next = up_valid[gi] & ~flush;

        always_ff @(posedge clock) begin
            if (reset) begin
                valid_reg  <= 1'b0;
                credit_reg <= 1'b0;
                data_reg   <= '0;
            end else begin
                valid_reg  <= valid_next;
                credit_reg <= up_credit[gi];
                // With hold enabled the payload only toggles for live
                // tokens, keeping the data bus quiet while idle.
                if (LOAD_ALWAYS || valid_next) begin
                    data_reg <= up_data[slice_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end

        assign dn_valid[gi]  = valid_reg;
        assign dn_credit[gi] = credit_reg;
        assign dn_data[slice_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = data_reg;
    end

endmodule

// File: rtl/credit_interconnect_pipe.sv
// Multi-stage, multi-channel credit interconnect pipe.
// Every channel's forward (data+valid) and reverse credit path is delayed by
// exactly NUM_STAGES cycles. Flush drops forward tokens in flight; credits
// always survive. Per-channel occupancy counts report tokens and credits
// currently held in the stage registers.
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   i_flush                : drop all forward tokens on every channel
//   i_data/i_valid         : forward input, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   i_increment_count      : credit return from downstream
//   o_data/o_valid         : delayed forward output
//   o_increment_count      : delayed credit return toward upstream
//   o_fwd_inflight         : per channel, valid tokens held (CNT_W bits each)
//   o_crd_inflight         : per channel, credits held (CNT_W bits each)
module credit_interconnect_pipe
    import credit_interconnect_pkg::*;
#(
    parameter int   DATA_WIDTH   = 32,
    parameter int   NUM_STAGES   = 2,
    parameter int   NUM_CHANNELS = 1,
    parameter int   HOLD_DATA    = 0,
    localparam int  CNT_W        = cnt_width(NUM_STAGES)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               i_flush,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CHANNELS-1:0]            i_valid,
    input  logic [NUM_CHANNELS-1:0]            i_increment_count,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_data,
    output logic [NUM_CHANNELS-1:0]            o_valid,
    output logic [NUM_CHANNELS-1:0]            o_increment_count,
    output logic [NUM_CHANNELS*CNT_W-1:0]      o_fwd_inflight,
    output logic [NUM_CHANNELS*CNT_W-1:0]      o_crd_inflight
);

    if (NUM_STAGES < 1) begin : g_bad_stages
        $error("credit_interconnect_pipe: NUM_STAGES must be >= 1");
    end
    if (NUM_CHANNELS < 1 || DATA_WIDTH < 1) begin : g_bad_width
        $error("credit_interconnect_pipe: NUM_CHANNELS and DATA_WIDTH must be >= 1");
    end

    // Element 0 is the pipe input; element s is the output of stage s.
    logic [NUM_CHANNELS-1:0]            valid_chain  [NUM_STAGES+1];
    logic [NUM_CHANNELS-1:0]            credit_chain [NUM_STAGES+1];
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_chain   [NUM_STAGES+1];

    assign valid_chain[0]  = i_valid;
    assign credit_chain[0] = i_increment_count;
    assign data_chain[0]   = i_data;

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        credit_interconnect_stage #(
            .DATA_WIDTH   (DATA_WIDTH),
            .NUM_CHANNELS (NUM_CHANNELS),
            .HOLD_DATA    (HOLD_DATA)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .flush     (i_flush),
            .up_valid  (valid_chain[gi]),
            .up_credit (credit_chain[gi]),
            .up_data   (data_chain[gi]),
            .dn_valid  (valid_chain[gi+1]),
            .dn_credit (credit_chain[gi+1]),
            .dn_data   (data_chain[gi+1])
        );
    end

    assign o_valid           = valid_chain[NUM_STAGES];
    assign o_increment_count = credit_chain[NUM_STAGES];
    assign o_data            = data_chain[NUM_STAGES];

    // Occupancy: popcount of stage registers 1..NUM_STAGES per channel.
    // CNT_W holds NUM_STAGES, so the sum cannot wrap.
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_cnt
        logic [CNT_W-1:0] fwd_cnt_next;
        logic [CNT_W-1:0] crd_cnt_next;

        always_comb begin
            fwd_cnt_next = '0;
            crd_cnt_next = '0;
            for (int s = 1; s <= NUM_STAGES; s++) begin
                fwd_cnt_next = fwd_cnt_next + CNT_W'(valid_chain[s][gi]);
                crd_cnt_next = crd_cnt_next + CNT_W'(credit_chain[s][gi]);
            end
        end

        assign o_fwd_inflight[slice_lsb(gi, CNT_W) +: CNT_W] = fwd_cnt_next;
        assign o_crd_inflight[slice_lsb(gi, CNT_W) +: CNT_W] = crd_cnt_next;
    end

endmodule

// File: tb/tb_credit_interconnect_pipe.sv
// Self-checking bench: a 4-channel, 3-stage, 32-bit pipe (load-always data)
// and a 1-channel, 3-stage, 8-bit pipe with data hold, both fed from the same
// stimulus. Expected outputs come from a history of sampled inputs: an output
// after edge e reflects the input sampled at edge e-N+1 unless a flush or
// reset edge lies in between.
module tb_credit_interconnect_pipe;

    localparam int N    = 3;
    localparam int NC   = 4;
    localparam int DW   = 32;
    localparam int CW   = 2;
    localparam int MAXE = 4096;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset   = 1'b0;
    logic               i_flush = 1'b0;
    logic [NC*DW-1:0]   i_data  = '0;
    logic [NC-1:0]      i_valid = '0;
    logic [NC-1:0]      i_inc   = '0;

    logic [NC*DW-1:0]   o_data;
    logic [NC-1:0]      o_valid;
    logic [NC-1:0]      o_inc;
    logic [NC*CW-1:0]   o_fwd;
    logic [NC*CW-1:0]   o_crd;

    logic [7:0]         h_o_data;
    logic               h_o_valid;
    logic               h_o_inc;
    logic [CW-1:0]      h_o_fwd;
    logic [CW-1:0]      h_o_crd;

    credit_interconnect_pipe #(
        .DATA_WIDTH(DW), .NUM_STAGES(N), .NUM_CHANNELS(NC), .HOLD_DATA(0)
    ) dut (
        .clock(clock), .reset(reset), .i_flush(i_flush),
        .i_data(i_data), .i_valid(i_valid), .i_increment_count(i_inc),
        .o_data(o_data), .o_valid(o_valid), .o_increment_count(o_inc),
        .o_fwd_inflight(o_fwd), .o_crd_inflight(o_crd)
    );

    credit_interconnect_pipe #(
        .DATA_WIDTH(8), .NUM_STAGES(N), .NUM_CHANNELS(1), .HOLD_DATA(1)
    ) dut_hold (
        .clock(clock), .reset(reset), .i_flush(i_flush),
        .i_data(i_data[7:0]), .i_valid(i_valid[0]), .i_increment_count(i_inc[0]),
        .o_data(h_o_data), .o_valid(h_o_valid), .o_increment_count(h_o_inc),
        .o_fwd_inflight(h_o_fwd), .o_crd_inflight(h_o_crd)
    );

    // Input history, one entry per rising edge.
    bit [NC-1:0] hv [MAXE];
    bit [NC-1:0] hc [MAXE];
    bit [DW-1:0] hd [MAXE][NC];
    bit          hf [MAXE];
    bit          hr [MAXE];
    int          e_cnt    = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, act, exp, e_cnt - 1);
    endtask

    function automatic bit fwd_killed(input int j, input int e);
        for (int k = j; k <= e; k++) if (hf[k] || hr[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit rst_in(input int j, input int e);
        for (int k = j; k <= e; k++) if (hr[k]) return 1'b1;
        return 1'b0;
    endfunction

    // Hold pipe: output shows the newest token that made it all the way
    // through, or 0 if a reset came after it.
    function automatic logic [7:0] exp_hold(input int e);
        int r;
        r = -1;
        for (int k = 0; k <= e; k++) if (hr[k]) r = k;
        for (int j = e - N + 1; j >= 0; j--) begin
            if (j <= r) return 8'h00;
            if (hv[j][0] && !fwd_killed(j, j + N - 1)) return hd[j][0][7:0];
        end
        return 8'h00;
    endfunction

    task automatic check_all(input int e);
        logic [NC-1:0] ev;
        logic [NC-1:0] ec;
        int            j;
        int            fc;
        int            cc;
        j = e - N + 1;
        for (int c = 0; c < NC; c++) begin
            logic [DW-1:0] ed;
            ev[c] = (j >= 0) && hv[j][c] && !fwd_killed(j, e);
            ec[c] = (j >= 0) && hc[j][c] && !rst_in(j, e);
            ed    = (j < 0 || rst_in(j, e)) ? '0 : hd[j][c];
            check($sformatf("data_ch%0d", c), 64'(o_data[c*DW +: DW]), 64'(ed));
            fc = 0;
            cc = 0;
            for (int k = 0; k < N; k++) begin
                if (e - k >= 0 && hv[e-k][c] && !fwd_killed(e - k, e)) fc++;
                if (e - k >= 0 && hc[e-k][c] && !rst_in(e - k, e)) cc++;
            end
            check($sformatf("fwd_cnt_ch%0d", c), 64'(o_fwd[c*CW +: CW]), 64'(fc));
            check($sformatf("crd_cnt_ch%0d", c), 64'(o_crd[c*CW +: CW]), 64'(cc));
            if (c == 0) begin
                check("hold_fwd_cnt", 64'(h_o_fwd), 64'(fc));
                check("hold_crd_cnt", 64'(h_o_crd), 64'(cc));
            end
        end
        check("valid", 64'(o_valid), 64'(ev));
        check("credit", 64'(o_inc), 64'(ec));
        check("hold_valid", 64'(h_o_valid), 64'(ev[0]));
        check("hold_credit", 64'(h_o_inc), 64'(ec[0]));
        check("hold_data", 64'(h_o_data), 64'(exp_hold(e)));
    endtask

    // One clock: record the inputs presented at this edge, then check outputs.
    task automatic step();
        if (e_cnt >= MAXE) begin
            $display("FAIL history_budget: got %0d edges, limit %0d", e_cnt, MAXE);
            $fatal(1);
        end
        @(posedge clock);
        hv[e_cnt] = i_valid;
        hc[e_cnt] = i_inc;
        hf[e_cnt] = i_flush;
        hr[e_cnt] = reset;
        for (int c = 0; c < NC; c++) hd[e_cnt][c] = i_data[c*DW +: DW];
        e_cnt++;
        if (|i_valid && !reset)
            $display("txn edge=%0d valid=%b credit=%b flush=%0b data=%h",
                     e_cnt - 1, i_valid, i_inc, i_flush, i_data);
        #1;
        check_all(e_cnt - 1);
    endtask

    task automatic idle(input int n);
        i_valid = '0; i_inc = '0; i_flush = 1'b0; i_data = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(2);

        // Latency: single token 0xA5 on channel 0
        i_valid = 4'b0001; i_data = '0; i_data[7:0] = 8'hA5;
        step();
        idle(N + 1);

        // Credit with valid together, then three back-to-back credits
        i_valid = 4'b0001; i_inc = 4'b0001; i_data[7:0] = 8'h11;
        step();
        idle(N + 1);
        i_inc = 4'b0001;
        for (int k = 0; k < 3; k++) step();
        check("crd_peak", 64'(o_crd[CW-1:0]), 64'd3);
        idle(N + 1);

        // Flush in the middle of a full stream with credits
        for (int k = 0; k < 10; k++) begin
            i_valid = '1; i_inc = 4'(k); i_flush = (k == 6);
            i_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (k == 6) check("flush_fwd_cnt_ch0", 64'(o_fwd[CW-1:0]), 64'd0);
        end
        idle(N + 1);

        // Reset with a full pipe of 0xFF and credits
        i_valid = '1; i_inc = '1; i_data = '1;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_crd_cnt", 64'(o_crd), 64'd0);
        i_valid = 4'b0101; i_inc = 4'b1000; i_data = {4{32'h0BADF00D}};
        step();
        idle(N + 1);

        // Hold: 0x3C then idle with 0x00 on the bus
        i_valid = 4'b0001; i_data = '0; i_data[7:0] = 8'h3C;
        step();
        idle(5);
        check("hold_idle_data", 64'(h_o_data), 64'h3C);

        // Multi-channel: valid on channel 2 only, distinct slices
        i_valid = 4'b0100;
        i_data  = {32'hDEADBEEF, 32'h22222222, 32'h11111111, 32'h00000000};
        step();
        i_valid = '0;
        step();
        step();
        check("ch3_slice", 64'(o_data[3*DW +: DW]), 64'hDEADBEEF);
        idle(N + 1);

        // Randomized traffic with occasional flush and reset
        for (int k = 0; k < 800; k++) begin
            i_valid = 4'($urandom);
            i_inc   = 4'($urandom);
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            i_flush = ($urandom_range(0, 15) == 0);
            reset   = ($urandom_range(0, 39) == 0);
            step();
        end
        reset = 1'b0;
        idle(N + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
